// File: rtl/uart_tx_controller.sv
// uart_tx_controller: buffers host bytes in a small FIFO, owns the word-length
// setting and paces the transmit shift register with load/shift strobes, one
// shift every OVERSAMPLE BCLK cycles. Status outputs are registered from the
// next-state values so they describe the machine as of the last edge.
module uart_tx_controller #(
  parameter int OVERSAMPLE = 16,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                          BCLK,
  input  logic                          RST_N,
  input  logic                          wr_en,
  input  logic [7:0]                    wr_data,
  input  logic                          cfg_we,
  input  logic [1:0]                    cfg_wsl,
  input  logic                          tx_en,
  input  logic                          clr_ovr,
  input  logic                          tsr_busy,
  output logic                          ts_load,
  output logic                          ts_shift,
  output logic [7:0]                    tsr_data,
  output logic [1:0]                    wsl,
  output logic                          fifo_full,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic                          thre,
  output logic                          temt,
  output logic                          overrun,
  output logic                          cfg_rej
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int LVL_W = PTR_W + 1;
  localparam int CNT_W = $clog2(OVERSAMPLE);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(OVERSAMPLE - 1);
  localparam logic [LVL_W-1:0] LVL_FULL = LVL_W'(FIFO_DEPTH);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    RUN  = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [PTR_W-1:0]   wrPtr_q, wrPtr_d;
  logic [PTR_W-1:0]   rdPtr_q, rdPtr_d;
  logic [LVL_W-1:0]   fifoLevel_q, fifoLevel_d;
  logic               fifoFull_q, fifoFull_d;
  logic               thre_q, thre_d;
  logic               temt_q, temt_d;
  logic               overrun_q, overrun_d;
  logic               cfgRej_q, cfgRej_d;
  logic [1:0]         wsl_q, wsl_d;
  logic               tsLoad_q, tsLoad_d;
  logic [7:0]         tsrData_q, tsrData_d;

  logic [7:0]         fifoMem [FIFO_DEPTH];

  logic               push;
  logic               pop;
  logic               startOk;
  logic               cfgOk;

  // Force the bits above the last data bit to 1 so the shifter sends a stop bit next.
  function automatic logic [7:0] maskByte(input logic [7:0] b, input logic [1:0] w);
    logic [7:0] r;
    case (w)
      2'd0:    r = b | 8'hE0;
      2'd1:    r = b | 8'hC0;
      2'd2:    r = b | 8'h80;
      default: r = b;
    endcase
    return r;
  endfunction

  // Next-state logic: frame sequencing, FIFO bookkeeping, config and status.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    wrPtr_d     = wrPtr_q;
    rdPtr_d     = rdPtr_q;
    fifoLevel_d = fifoLevel_q;
    overrun_d   = overrun_q;
    wsl_d       = wsl_q;
    cfgRej_d    = 1'b0;
    tsrData_d   = tsrData_q;

    push    = wr_en && !fifoFull_q;
    startOk = (fifoLevel_q != '0) && tx_en;
    cfgOk   = (state_q == IDLE) && (fifoLevel_q == '0);

    case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (startOk) state_d = LOAD;
      end
      LOAD: begin
        cnt_d   = '0;
        state_d = RUN;
      end
      RUN: begin
        cnt_d = (cnt_q == CNT_MAX) ? '0 : cnt_q + CNT_W'(1);
        if ((cnt_q == CNT_MAX) && !tsr_busy) state_d = startOk ? LOAD : IDLE;
      end
      default: begin
        cnt_d   = '0;
        state_d = IDLE;
      end
    endcase

    pop      = (state_d == LOAD);
    tsLoad_d = pop;
    if (pop) begin
      tsrData_d = maskByte(fifoMem[rdPtr_q], wsl_q);
      rdPtr_d   = rdPtr_q + PTR_W'(1);
    end
    if (push) wrPtr_d = wrPtr_q + PTR_W'(1);

    case ({push, pop})
      2'b10:   fifoLevel_d = fifoLevel_q + LVL_W'(1);
      2'b01:   fifoLevel_d = fifoLevel_q - LVL_W'(1);
      default: fifoLevel_d = fifoLevel_q;
    endcase

    fifoFull_d = (fifoLevel_d == LVL_FULL);
    thre_d     = (fifoLevel_d == '0);
    temt_d     = thre_d && (state_d == IDLE);

    if (wr_en && fifoFull_q) overrun_d = 1'b1;
    else if (clr_ovr)        overrun_d = 1'b0;

    if (cfg_we) begin
      if (cfgOk) wsl_d    = cfg_wsl;
      else       cfgRej_d = 1'b1;
    end
  end

  // State, counters, pointers and registered outputs with synchronous active-low reset.
  always_ff @(posedge BCLK) begin
    if (!RST_N) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      wrPtr_q     <= '0;
      rdPtr_q     <= '0;
      fifoLevel_q <= '0;
      fifoFull_q  <= 1'b0;
      thre_q      <= 1'b1;
      temt_q      <= 1'b1;
      overrun_q   <= 1'b0;
      cfgRej_q    <= 1'b0;
      wsl_q       <= 2'd3;
      tsLoad_q    <= 1'b0;
      tsrData_q   <= 8'hFF;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      wrPtr_q     <= wrPtr_d;
      rdPtr_q     <= rdPtr_d;
      fifoLevel_q <= fifoLevel_d;
      fifoFull_q  <= fifoFull_d;
      thre_q      <= thre_d;
      temt_q      <= temt_d;
      overrun_q   <= overrun_d;
      cfgRej_q    <= cfgRej_d;
      wsl_q       <= wsl_d;
      tsLoad_q    <= tsLoad_d;
      tsrData_q   <= tsrData_d;
    end
  end

  // FIFO storage needs no reset; the pointers and level define what is valid.
  always_ff @(posedge BCLK) begin
    if (push) fifoMem[wrPtr_q] <= wr_data;
  end

  assign ts_load    = tsLoad_q;
  assign ts_shift   = (state_q == RUN) && (cnt_q == '0) && tsr_busy;
  assign tsr_data   = tsrData_q;
  assign wsl        = wsl_q;
  assign fifo_full  = fifoFull_q;
  assign fifo_level = fifoLevel_q;
  assign thre       = thre_q;
  assign temt       = temt_q;
  assign overrun    = overrun_q;
  assign cfg_rej    = cfgRej_q;

endmodule

// File: tb/tb_uart_tx_controller.sv
// tb_uart_tx_controller: directed bench for the UART transmit controller with a
// behavioural shift-register model supplying tsr_busy.
module tb_uart_tx_controller;

  logic       BCLK = 1'b0;
  logic       RST_N;
  logic       wr_en;
  logic [7:0] wr_data;
  logic       cfg_we;
  logic [1:0] cfg_wsl;
  logic       tx_en;
  logic       clr_ovr;
  logic       tsr_busy;
  logic       ts_load;
  logic       ts_shift;
  logic [7:0] tsr_data;
  logic [1:0] wsl;
  logic       fifo_full;
  logic [2:0] fifo_level;
  logic       thre;
  logic       temt;
  logic       overrun;
  logic       cfg_rej;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int modelW = 10;
  int mRem = 0;
  logic mBusy = 1'b0;

  int         loadTimes[$];
  logic [7:0] loadData[$];
  int         shiftTimes[$];
  int         temtRise[$];
  logic       temtPrev = 1'b0;
  logic       overlap = 1'b0;

  int w;
  int e;
  int L;
  logic [7:0] expBytes [4];

  uart_tx_controller #(.OVERSAMPLE(16), .FIFO_DEPTH(4)) dut (
    .BCLK(BCLK), .RST_N(RST_N), .wr_en(wr_en), .wr_data(wr_data),
    .cfg_we(cfg_we), .cfg_wsl(cfg_wsl), .tx_en(tx_en), .clr_ovr(clr_ovr),
    .tsr_busy(tsr_busy), .ts_load(ts_load), .ts_shift(ts_shift),
    .tsr_data(tsr_data), .wsl(wsl), .fifo_full(fifo_full),
    .fifo_level(fifo_level), .thre(thre), .temt(temt), .overrun(overrun),
    .cfg_rej(cfg_rej)
  );

  always #5 BCLK = ~BCLK;

  // Cycle counter: the value seen at a negedge names the interval after that many edges.
  always @(posedge BCLK) cyc <= cyc + 1;

  // Shift-register model: busy from load until modelW shifts have been taken.
  always @(posedge BCLK) begin
    if (!RST_N) begin
      mBusy <= 1'b0;
      mRem  <= 0;
    end else if (ts_load === 1'b1) begin
      mBusy <= 1'b1;
      mRem  <= modelW;
    end else if (ts_shift === 1'b1) begin
      mRem <= mRem - 1;
      if (mRem == 1) mBusy <= 1'b0;
    end
  end
  assign tsr_busy = mBusy;

  // Event log of strobes and temt rising edges, sampled mid-cycle.
  always @(negedge BCLK) begin
    if (ts_load === 1'b1) begin
      loadTimes.push_back(cyc);
      loadData.push_back(tsr_data);
    end
    if (ts_shift === 1'b1) shiftTimes.push_back(cyc);
    if (ts_load === 1'b1 && ts_shift === 1'b1) overlap = 1'b1;
    if (temt === 1'b1 && !temtPrev) temtRise.push_back(cyc);
    temtPrev = (temt === 1'b1);
  end

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic applyStimulus(input logic we, input logic [7:0] data, input logic cw,
                               input logic [1:0] cwsl, input logic clr);
    wr_en   = we;
    wr_data = data;
    cfg_we  = cw;
    cfg_wsl = cwsl;
    clr_ovr = clr;
    @(negedge BCLK);
    wr_en   = 1'b0;
    cfg_we  = 1'b0;
    clr_ovr = 1'b0;
  endtask

  task automatic waitCycles(input int n);
    repeat (n) @(negedge BCLK);
  endtask

  task automatic clearLogs();
    loadTimes.delete();
    loadData.delete();
    shiftTimes.delete();
    temtRise.delete();
    overlap = 1'b0;
  endtask

  task automatic checkResetValues(input string pfx);
    checkOutput({pfx, "_ts_load"}, ts_load, 0);
    checkOutput({pfx, "_ts_shift"}, ts_shift, 0);
    checkOutput({pfx, "_tsr_data"}, tsr_data, 8'hFF);
    checkOutput({pfx, "_wsl"}, wsl, 3);
    checkOutput({pfx, "_fifo_full"}, fifo_full, 0);
    checkOutput({pfx, "_fifo_level"}, fifo_level, 0);
    checkOutput({pfx, "_thre"}, thre, 1);
    checkOutput({pfx, "_temt"}, temt, 1);
    checkOutput({pfx, "_overrun"}, overrun, 0);
    checkOutput({pfx, "_cfg_rej"}, cfg_rej, 0);
  endtask

  initial begin
    RST_N = 1'b0; wr_en = 1'b0; wr_data = 8'h00; cfg_we = 1'b0;
    cfg_wsl = 2'd0; tx_en = 1'b1; clr_ovr = 1'b0;

    // Reset values
    waitCycles(3);
    checkResetValues("rst");
    RST_N = 1'b1;
    waitCycles(2);

    // Single 8-bit byte
    $display("[TB] single byte");
    modelW = 10;
    clearLogs();
    w = cyc;
    applyStimulus(1'b1, 8'hA5, 1'b0, 2'd0, 1'b0);
    waitCycles(200);
    L = w + 2;
    checkOutput("t1_loadCount", loadTimes.size(), 1);
    checkOutput("t1_loadTime", (loadTimes.size() > 0) ? loadTimes[0] : -1, L);
    checkOutput("t1_loadData", (loadData.size() > 0) ? loadData[0] : 8'h00, 8'hA5);
    checkOutput("t1_shiftCount", shiftTimes.size(), 10);
    for (int k = 0; k < shiftTimes.size(); k++)
      checkOutput($sformatf("t1_shift%0d", k), shiftTimes[k], L + 1 + 16 * k);
    checkOutput("t1_temtRise", (temtRise.size() > 0) ? temtRise[$] : -1, L + 161);
    checkOutput("t1_overlap", overlap, 0);

    // 5-bit word
    $display("[TB] 5-bit word");
    applyStimulus(1'b0, 8'h00, 1'b1, 2'd0, 1'b0);
    checkOutput("t2_wsl", wsl, 0);
    checkOutput("t2_cfgRej", cfg_rej, 0);
    modelW = 7;
    clearLogs();
    w = cyc;
    applyStimulus(1'b1, 8'h00, 1'b0, 2'd0, 1'b0);
    waitCycles(150);
    L = w + 2;
    checkOutput("t2_loadCount", loadTimes.size(), 1);
    checkOutput("t2_loadData", (loadData.size() > 0) ? loadData[0] : 8'h00, 8'hE0);
    checkOutput("t2_shiftCount", shiftTimes.size(), 7);
    checkOutput("t2_lastShift", (shiftTimes.size() > 0) ? shiftTimes[$] : -1, L + 97);
    checkOutput("t2_temtRise", (temtRise.size() > 0) ? temtRise[$] : -1, L + 113);
    applyStimulus(1'b0, 8'h00, 1'b1, 2'd3, 1'b0);
    checkOutput("t2_wslRestore", wsl, 3);

    // Fill the FIFO, then release back-to-back frames
    $display("[TB] back-to-back");
    modelW = 10;
    tx_en = 1'b0;
    clearLogs();
    expBytes = '{8'h11, 8'h22, 8'h33, 8'h44};
    for (int i = 0; i < 4; i++) applyStimulus(1'b1, expBytes[i], 1'b0, 2'd0, 1'b0);
    checkOutput("t3_full", fifo_full, 1);
    checkOutput("t3_level", fifo_level, 4);
    checkOutput("t3_thre", thre, 0);
    checkOutput("t3_temt", temt, 0);
    applyStimulus(1'b0, 8'h00, 1'b1, 2'd1, 1'b0);
    checkOutput("t3_cfgRej", cfg_rej, 1);
    checkOutput("t3_wslKept", wsl, 3);
    e = cyc;
    tx_en = 1'b1;
    waitCycles(700);
    L = e + 1;
    checkOutput("t3_loadCount", loadTimes.size(), 4);
    for (int k = 0; k < loadTimes.size() && k < 4; k++) begin
      checkOutput($sformatf("t3_loadTime%0d", k), loadTimes[k], L + 161 * k);
      checkOutput($sformatf("t3_loadData%0d", k), loadData[k], expBytes[k]);
    end
    checkOutput("t3_shiftCount", shiftTimes.size(), 40);
    checkOutput("t3_overlap", overlap, 0);
    checkOutput("t3_threEnd", thre, 1);
    checkOutput("t3_temtEnd", temt, 1);

    // Overrun behaviour
    $display("[TB] overrun");
    tx_en = 1'b0;
    clearLogs();
    for (int i = 0; i < 6; i++) applyStimulus(1'b1, 8'(8'h51 + i), 1'b0, 2'd0, 1'b0);
    checkOutput("t4_level", fifo_level, 4);
    checkOutput("t4_full", fifo_full, 1);
    checkOutput("t4_overrun", overrun, 1);
    applyStimulus(1'b0, 8'h00, 1'b0, 2'd0, 1'b1);
    checkOutput("t4_cleared", overrun, 0);
    applyStimulus(1'b1, 8'h60, 1'b0, 2'd0, 1'b1);
    checkOutput("t4_setWinsClr", overrun, 1);
    checkOutput("t4_levelHeld", fifo_level, 4);
    applyStimulus(1'b0, 8'h00, 1'b0, 2'd0, 1'b1);
    checkOutput("t4_cleared2", overrun, 0);
    tx_en = 1'b1;
    applyStimulus(1'b1, 8'h99, 1'b0, 2'd0, 1'b0);
    checkOutput("t4_popLoad", ts_load, 1);
    checkOutput("t4_popData", tsr_data, 8'h51);
    checkOutput("t4_popLevel", fifo_level, 3);
    checkOutput("t4_popOverrun", overrun, 1);
    waitCycles(700);
    checkOutput("t4_loadCount", loadTimes.size(), 4);
    for (int k = 0; k < loadData.size() && k < 4; k++)
      checkOutput($sformatf("t4_loadData%0d", k), loadData[k], 8'(8'h51 + k));
    checkOutput("t4_sticky", overrun, 1);
    checkOutput("t4_temtEnd", temt, 1);
    applyStimulus(1'b0, 8'h00, 1'b0, 2'd0, 1'b1);
    checkOutput("t4_finalClr", overrun, 0);

    // Config rejection and tx_en drop mid-frame
    $display("[TB] config reject / tx_en drop");
    clearLogs();
    tx_en = 1'b1;
    applyStimulus(1'b1, 8'h3C, 1'b0, 2'd0, 1'b0);
    applyStimulus(1'b1, 8'hC3, 1'b0, 2'd0, 1'b0);
    waitCycles(20);
    applyStimulus(1'b0, 8'h00, 1'b1, 2'd1, 1'b0);
    checkOutput("t5_cfgRej", cfg_rej, 1);
    checkOutput("t5_wslKept", wsl, 3);
    waitCycles(1);
    checkOutput("t5_cfgRejPulse", cfg_rej, 0);
    tx_en = 1'b0;
    waitCycles(300);
    checkOutput("t5_loadCount", loadTimes.size(), 1);
    checkOutput("t5_loadData", (loadData.size() > 0) ? loadData[0] : 8'h00, 8'h3C);
    checkOutput("t5_shiftCount", shiftTimes.size(), 10);
    checkOutput("t5_level", fifo_level, 1);
    checkOutput("t5_thre", thre, 0);
    checkOutput("t5_temt", temt, 0);

    // Reset in the middle of a frame
    $display("[TB] reset mid-frame");
    applyStimulus(1'b1, 8'h77, 1'b0, 2'd0, 1'b0);
    checkOutput("t6_levelBefore", fifo_level, 2);
    clearLogs();
    e = cyc;
    tx_en = 1'b1;
    L = e + 1;
    while (cyc < L + 49) @(negedge BCLK);
    RST_N = 1'b0;
    waitCycles(1);
    checkResetValues("t6");
    RST_N = 1'b1;
    waitCycles(40);
    checkOutput("t6_loadCount", loadTimes.size(), 1);
    checkOutput("t6_loadData", (loadData.size() > 0) ? loadData[0] : 8'h00, 8'hC3);
    checkOutput("t6_shiftCount", shiftTimes.size(), 4);
    checkOutput("t6_levelAfter", fifo_level, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
